// File: rtl/hid_key_events_if.sv
// Key-event stream: show-ahead head entry with a valid/ready handshake.
// Entry layout is {repeat, press, code[7:0], modifiers[7:0]}.
interface hid_key_events_if;
    logic        ev_valid;
    logic        ev_ready;
    logic [17:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/hid_key_events.sv
// Diffs successive HID keyboard reports into press/release events, adds typematic
// repeat for the last pressed key and queues everything in a show-ahead FIFO.
//
// state  | meaning
// IDLE   | waiting for a report; repeat timer may fire
// SCAN   | walking 16 candidates (4 old slots, 8 modifier bits, 4 new slots)
module hid_key_events #(
    parameter int DEPTH        = 16,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 6000000,
    parameter int REPEAT_RATE  = 400000
) (
    input  logic             usbclk,
    input  logic             usbrst,
    input  logic             report,
    input  logic [1:0]       typ,
    input  logic [7:0]       key_modifiers,
    input  logic [7:0]       key1,
    input  logic [7:0]       key2,
    input  logic [7:0]       key3,
    input  logic [7:0]       key4,
    hid_key_events_if.master ev,
    output logic             busy,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0][7:0] old_keys_q, old_keys_d, new_keys_q, new_keys_d;
    logic [7:0]      old_mods_q, old_mods_d, new_mods_q, new_mods_d;
    logic            rpt_on_q, rpt_on_d;
    logic [7:0]      rpt_code_q, rpt_code_d;
    logic [TW-1:0]   rpt_tmr_q, rpt_tmr_d;
    logic [17:0]     mem_q [DEPTH];
    logic [AW:0]     wr_q, rd_q;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_q, drop_d;

    logic [3:0][7:0] in_keys;
    logic            rollover, scanning;
    logic            cand_hit, cand_press;
    logic [7:0]      cand_code;
    logic [2:0]      mod_sel;
    logic            scan_push, rpt_fire, push, pop, full, empty, wr_en, drop_ev;
    logic [17:0]     push_data;
    logic [AW:0]     count;
    logic [1:0]      drop_inc;
    logic [8:0]      drop_sum;

    assign in_keys  = {key4, key3, key2, key1};
    assign rollover = (key1 == 8'h01) || (key2 == 8'h01) || (key3 == 8'h01) || (key4 == 8'h01);
    assign scanning = (state_q == S_SCAN);
    assign mod_sel  = idx_q[2:0] - 3'd4;

    // Candidate for the current scan index; duplicates among new slots press only once.
    always_comb begin
        cand_hit   = 1'b0;
        cand_press = 1'b0;
        cand_code  = 8'h00;
        if (idx_q < 4'd4) begin
            cand_code = old_keys_q[idx_q[1:0]];
            cand_hit  = (cand_code != 8'h00);
            for (int j = 0; j < 4; j++)
                if (new_keys_q[j] == cand_code) cand_hit = 1'b0;
        end else if (idx_q < 4'd12) begin
            cand_code  = 8'hE0 + {5'd0, mod_sel};
            cand_press = new_mods_q[mod_sel];
            cand_hit   = (new_mods_q[mod_sel] != old_mods_q[mod_sel]);
        end else begin
            cand_code  = new_keys_q[idx_q[1:0]];
            cand_press = 1'b1;
            cand_hit   = (cand_code != 8'h00);
            for (int j = 0; j < 4; j++) begin
                if (old_keys_q[j] == cand_code) cand_hit = 1'b0;
                if ((j < int'(idx_q[1:0])) && (new_keys_q[j] == cand_code)) cand_hit = 1'b0;
            end
        end
    end

    assign scan_push = scanning && cand_hit;
    assign rpt_fire  = (REPEAT_EN != 0) && !scanning && rpt_on_q && (rpt_tmr_q == '0);
    assign push      = scan_push || rpt_fire;
    assign push_data = scanning ? {1'b0, cand_press, cand_code, new_mods_q}
                                : {2'b11, rpt_code_q, old_mods_q};

    assign count   = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = !empty && ev.ev_ready;
    assign wr_en   = push && (!full || pop);
    assign drop_ev = push && full && !pop;

    // Timer counts down in both states but only fires in IDLE, so it parks at zero during a scan.
    always_comb begin
        rpt_on_d   = rpt_on_q;
        rpt_code_d = rpt_code_q;
        rpt_tmr_d  = rpt_tmr_q;
        if (REPEAT_EN != 0) begin
            if (scan_push && !cand_press && rpt_on_q && (cand_code == rpt_code_q)) begin
                rpt_on_d  = 1'b0;
                rpt_tmr_d = '0;
            end else if (scan_push && (idx_q >= 4'd12)) begin
                rpt_on_d   = 1'b1;
                rpt_code_d = cand_code;
                rpt_tmr_d  = T_DELAY;
            end else if (rpt_fire) begin
                rpt_tmr_d = T_RATE;
            end else if (rpt_on_q && (rpt_tmr_q != '0)) begin
                rpt_tmr_d = rpt_tmr_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        old_keys_d = old_keys_q;
        old_mods_d = old_mods_q;
        new_keys_d = new_keys_q;
        new_mods_d = new_mods_q;
        overflow_d = overflow_q || drop_ev;
        drop_inc   = {1'b0, drop_ev};
        case (state_q)
            S_IDLE: begin
                if (report && (typ == 2'd1)) begin
                    if (rollover) begin
                        drop_inc = drop_inc + 2'd1;
                    end else begin
                        new_keys_d = in_keys;
                        new_mods_d = key_modifiers;
                        idx_d      = 4'd0;
                        state_d    = S_SCAN;
                    end
                end else if (report && (typ == 2'd0) && (|old_keys_q)) begin
                    new_keys_d = '0;
                    new_mods_d = 8'h00;
                    idx_d      = 4'd0;
                    state_d    = S_SCAN;
                end
            end
            default: begin
                if (report) drop_inc = drop_inc + 2'd1;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    old_keys_d = new_keys_q;
                    old_mods_d = new_mods_q;
                    state_d    = S_IDLE;
                end
            end
        endcase
        drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            old_keys_q <= '0;
            old_mods_q <= 8'h00;
            new_keys_q <= '0;
            new_mods_q <= 8'h00;
            rpt_on_q   <= 1'b0;
            rpt_code_q <= 8'h00;
            rpt_tmr_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            old_keys_q <= old_keys_d;
            old_mods_q <= old_mods_d;
            new_keys_q <= new_keys_d;
            new_mods_q <= new_mods_d;
            rpt_on_q   <= rpt_on_d;
            rpt_code_q <= rpt_code_d;
            rpt_tmr_q  <= rpt_tmr_d;
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge usbclk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    assign ev.ev_valid = !empty;
    assign ev.ev_data  = empty ? 18'h0 : mem_q[rd_q[AW-1:0]];
    assign busy        = scanning;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_hid_key_events.sv
// Directed scenarios plus a random run, each cycle compared against an event-list
// model (report diff tables, a queue for the FIFO and an absolute repeat deadline).
module tb_hid_key_events;
    localparam int DEPTH = 4;
    localparam int DELAY = 100;
    localparam int RATE  = 20;

    logic       usbclk = 1'b0;
    logic       usbrst, report;
    logic [1:0] typ;
    logic [7:0] key_modifiers, key1, key2, key3, key4;
    logic       busy, overflow;
    logic [7:0] drop_cnt;

    hid_key_events_if ev();

    hid_key_events #(.DEPTH(DEPTH), .REPEAT_EN(1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) dut (
        .usbclk(usbclk), .usbrst(usbrst), .report(report), .typ(typ),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .ev(ev), .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 usbclk = ~usbclk;

    // model state
    logic [17:0] m_fifo[$];
    logic [7:0]  m_old[4], m_new[4];
    logic [7:0]  m_old_mods, m_new_mods;
    logic [18:0] m_sched[16];
    int          m_left, m_drops;
    bit          m_ovf, m_tvalid;
    logic [7:0]  m_target;
    longint      m_due, cyc;

    int          vectors = 0, miscompares = 0;
    logic [17:0] seen[$];
    longint      seen_t[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] seen_at(input int i);
        return (i < seen.size()) ? seen[i] : 18'h3FFFF;
    endfunction

    function automatic longint seen_time(input int i);
        return (i < seen_t.size()) ? seen_t[i] : -1;
    endfunction

    task automatic plan();
        bit hit;
        for (int i = 0; i < 4; i++) begin
            hit = 0;
            for (int j = 0; j < 4; j++) if (m_new[j] == m_old[i]) hit = 1;
            m_sched[i] = (m_old[i] != 0 && !hit) ? {3'b100, m_old[i], m_new_mods} : 19'h0;
        end
        for (int b = 0; b < 8; b++)
            m_sched[4+b] = (m_old_mods[b] != m_new_mods[b])
                         ? {2'b10, m_new_mods[b], 8'(8'hE0 + b), m_new_mods} : 19'h0;
        for (int i = 0; i < 4; i++) begin
            hit = 0;
            for (int j = 0; j < 4; j++) if (m_old[j] == m_new[i]) hit = 1;
            for (int j = 0; j < i; j++) if (m_new[j] == m_new[i]) hit = 1;
            m_sched[12+i] = (m_new[i] != 0 && !hit) ? {3'b101, m_new[i], m_new_mods} : 19'h0;
        end
        m_left = 16;
    endtask

    task automatic model_reset();
        m_fifo.delete();
        for (int i = 0; i < 4; i++) begin m_old[i] = 0; m_new[i] = 0; end
        m_old_mods = 0; m_new_mods = 0; m_left = 0; m_drops = 0; m_ovf = 0;
        m_tvalid = 0; m_target = 0; m_due = 0;
    endtask

    task automatic model_cycle(input bit rep, input logic [1:0] t, input logic [7:0] mods,
                               input logic [7:0] k1, k2, k3, k4, input bit rdy);
        bit pop, have_push, any_old;
        logic [17:0] pdata;
        logic [18:0] e;
        int idx;
        pop = (m_fifo.size() > 0) && rdy;
        have_push = 0;
        pdata = 0;
        if (m_left > 0) begin
            idx = 16 - m_left;
            e = m_sched[idx];
            if (e[18]) begin
                have_push = 1;
                pdata = e[17:0];
                if (!e[16] && m_tvalid && e[15:8] == m_target) m_tvalid = 0;
                if (e[16] && idx >= 12) begin m_tvalid = 1; m_target = e[15:8]; m_due = cyc + DELAY; end
            end
            if (rep) m_drops++;
        end else if (m_tvalid && cyc >= m_due) begin
            have_push = 1;
            pdata = {2'b11, m_target, m_old_mods};
            m_due = cyc + RATE;
        end
        if (pop) void'(m_fifo.pop_front());
        if (have_push) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(pdata);
            else begin m_ovf = 1; m_drops++; end
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_old = m_new; m_old_mods = m_new_mods; end
        end else if (rep) begin
            any_old = 0;
            for (int i = 0; i < 4; i++) if (m_old[i] != 0) any_old = 1;
            if (t == 2'd1) begin
                if (k1 == 8'h01 || k2 == 8'h01 || k3 == 8'h01 || k4 == 8'h01) m_drops++;
                else begin m_new = '{k1, k2, k3, k4}; m_new_mods = mods; plan(); end
            end else if (t == 2'd0 && any_old) begin
                m_new = '{8'h0, 8'h0, 8'h0, 8'h0}; m_new_mods = 0; plan();
            end
        end
        if (m_drops > 255) m_drops = 255;
    endtask

    task automatic step(input bit rst, input bit rep, input logic [1:0] t, input logic [7:0] mods,
                        input logic [7:0] k1, k2, k3, k4, input bit rdy);
        usbrst = rst; report = rep; typ = t; key_modifiers = mods;
        key1 = k1; key2 = k2; key3 = k3; key4 = k4; ev.ev_ready = rdy;
        #1;
        if (!rst && ev.ev_valid && rdy) begin seen.push_back(ev.ev_data); seen_t.push_back(cyc); end
        if (rst) model_reset();
        else model_cycle(rep, t, mods, k1, k2, k3, k4, rdy);
        @(posedge usbclk);
        #1;
        cyc++;
        chk("ev_valid", {31'd0, ev.ev_valid}, {31'd0, m_fifo.size() > 0});
        chk("ev_data", {14'd0, ev.ev_data}, {14'd0, (m_fifo.size() > 0) ? m_fifo[0] : 18'h0});
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_cnt", {24'd0, drop_cnt}, 32'(m_drops));
    endtask

    task automatic rep_kb(input logic [7:0] mods, k1, k2, k3, k4, input bit rdy);
        step(0, 1, 2'd1, mods, k1, k2, k3, k4, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 2'd1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, rdy);
    endtask

    function automatic logic [7:0] rkey();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 8'h00;
        if (r == 9) return ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h04;
        return 8'(r);
    endfunction

    initial begin
        int bcnt;
        logic [7:0] rk[4];
        logic [7:0] rm;
        logic [1:0] rt;
        cyc = 0;
        model_reset();
        ev.ev_ready = 1'b1;

        // reset state
        step(1, 0, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1);
        step(1, 0, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1);
        chk("rst_valid", {31'd0, ev.ev_valid}, 0);
        chk("rst_data", {14'd0, ev.ev_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_drop", {24'd0, drop_cnt}, 0);

        // press 'a': visible 14 cycles after the report, busy for 16
        rep_kb(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        bcnt = busy;
        for (int i = 0; i < 20; i++) begin
            idle(1, 1);
            bcnt += busy;
            if (i == 11) chk("press_a_early", {31'd0, ev.ev_valid}, 0);
            if (i == 12) chk("press_a_event", {13'd0, ev.ev_valid, ev.ev_data}, {13'd0, 1'b1, 18'h10400});
        end
        chk("press_a_busy", 32'(bcnt), 16);

        // release after short hold, no repeat
        seen.delete(); seen_t.delete();
        rep_kb(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        idle(30, 1);
        chk("release_cnt", 32'(seen.size()), 1);
        chk("release_ev", {14'd0, seen_at(0)}, {14'd0, 18'h00400});

        // shift + key change
        rep_kb(8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        idle(20, 1);
        seen.delete(); seen_t.delete();
        rep_kb(8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 1);
        idle(20, 1);
        chk("shift_cnt", 32'(seen.size()), 3);
        chk("shift_ev0", {14'd0, seen_at(0)}, {14'd0, 18'h00400});
        chk("shift_ev1", {14'd0, seen_at(1)}, {14'd0, 18'h0E100});
        chk("shift_ev2", {14'd0, seen_at(2)}, {14'd0, 18'h10500});

        // auto-repeat
        seen.delete(); seen_t.delete();
        rep_kb(8'h00, 8'h1E, 8'h00, 8'h00, 8'h00, 1);
        idle(165, 1);
        chk("rpt_cnt", 32'(seen.size()), 5);
        chk("rpt_press", {14'd0, seen_at(1)}, {14'd0, 18'h11E00});
        chk("rpt_ev1", {14'd0, seen_at(2)}, {14'd0, 18'h31E00});
        chk("rpt_ev3", {14'd0, seen_at(4)}, {14'd0, 18'h31E00});
        chk("rpt_delay", 32'(seen_time(2) - seen_time(1)), DELAY);
        chk("rpt_rate", 32'(seen_time(3) - seen_time(2)), RATE);
        seen.delete(); seen_t.delete();
        rep_kb(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        idle(150, 1);
        chk("rpt_stop_cnt", 32'(seen.size()), 1);
        chk("rpt_stop_ev", {14'd0, seen_at(0)}, {14'd0, 18'h01E00});

        // disconnect releases held keys
        rep_kb(8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 1);
        idle(20, 1);
        seen.delete(); seen_t.delete();
        step(0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        idle(20, 1);
        chk("disc_cnt", 32'(seen.size()), 2);
        chk("disc_ev0", {14'd0, seen_at(0)}, {14'd0, 18'h00400});
        chk("disc_ev1", {14'd0, seen_at(1)}, {14'd0, 18'h00500});

        // overflow, report during scan, rollover
        rep_kb(8'h0F, 8'h04, 8'h05, 8'h06, 8'h07, 0);
        idle(2, 0);
        rep_kb(8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 0);
        idle(16, 0);
        chk("ovf_flag", {31'd0, overflow}, 1);
        chk("ovf_drop", {24'd0, drop_cnt}, 5);
        chk("ovf_head", {14'd0, ev.ev_data}, {14'd0, 18'h1E00F});
        rep_kb(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        idle(2, 0);
        chk("roll_drop", {24'd0, drop_cnt}, 6);
        chk("roll_busy", {31'd0, busy}, 0);

        step(1, 0, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1);
        step(1, 0, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1);
        chk("rst2_ovf", {31'd0, overflow}, 0);

        // random traffic
        for (int i = 0; i < 4; i++) rk[i] = 0;
        rm = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 9) >= 3) begin
                    for (int i = 0; i < 4; i++) rk[i] = rkey();
                    rm = 8'($urandom_range(0, 255)) & 8'h13;
                end
                case ($urandom_range(0, 19))
                    0, 1, 2: rt = 2'd0;
                    3:       rt = 2'd2;
                    4:       rt = 2'd3;
                    default: rt = 2'd1;
                endcase
                step(0, 1, rt, rm, rk[0], rk[1], rk[2], rk[3], $urandom_range(0, 3) != 0);
            end else begin
                step(0, 0, 2'd1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, $urandom_range(0, 3) != 0);
            end
        end

        // reset in the middle of a scan
        idle(40, 1);
        rep_kb(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        idle(5, 1);
        step(1, 0, 2'd1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1);
        chk("midrst_valid", {31'd0, ev.ev_valid}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        idle(20, 1);
        chk("midrst_after", {31'd0, ev.ev_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
